stage_three: RTL and testbench
==============================

STAGE_THREE -- requirements
Module: stage_three

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock (rising edge); rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: halt_sys  in  1  system halt; in_memc  in  2  memory control from stage two (types_pkg::memc_t); in_alu  in  32  ALU result; in_r1_data  in  16  store data; in_r0_en  in  1  writeback enable; in_instr  in  16  instruction.
REQ-003 SHALL have ports: mem_req  out  1  data-memory request; mem_we  out  1  write enable; mem_addr  out  16  address; mem_wdata  out  16  write data; mem_rdata  in  16  read data; mem_ack  in  1  access complete.
REQ-004 SHALL have ports: stall_out  out  1  hold upstream stages; out_wb_data  out  32  writeback value; out_r0_en  out  1  writeback enable; out_instr  out  16  instruction; out_valid  out  1  output slot holds a retired instruction; out_mem_err  out  1  access aborted.

Function
REQ-005 in_memc decode SHALL be: 2'b00 none; 2'b01 load; 2'b10 store; 2'b11 treated as none.
REQ-006 FSM SHALL have two states: IDLE and WAIT.
REQ-007 In IDLE with a load/store and halt_sys=0, the next edge SHALL assert mem_req and enter WAIT. mem_addr SHALL be in_alu[15:0]. mem_wdata SHALL be in_r1_data. mem_we SHALL be 1 for store and 0 for load.
REQ-008 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and held stable throughout WAIT.
REQ-009 stall_out SHALL be combinational and equal (IDLE and load/store and !halt_sys) or (WAIT and !mem_ack).
REQ-010 In WAIT, a cycle with mem_ack=1 SHALL drop mem_req at the next edge, return the FSM to IDLE, and update the output flops in that same edge.
REQ-011 Load retire SHALL set out_wb_data={16'd0,mem_rdata}, out_r0_en=in_r0_en, out_valid=1.
REQ-012 Store retire SHALL set out_wb_data=in_alu, out_r0_en=0, out_valid=1.
REQ-013 A non-memory instruction in IDLE with halt_sys=0 SHALL flop at the next edge: out_wb_data=in_alu, out_r0_en=in_r0_en, out_instr=in_instr, out_valid=1. Latency SHALL be 1 cycle, with no stall.
REQ-014 While a load/store is pending (IDLE launch cycle and non-ack WAIT cycles), the output flops SHALL present a bubble: out_valid=0 and out_r0_en=0. out_wb_data and out_instr SHALL hold their values.
REQ-015 Memory-op latency SHALL be 2 cycles plus the number of non-ack WAIT cycles.
REQ-016 In IDLE, halt_sys=1 SHALL freeze all output flops and block launches.
REQ-017 In WAIT, halt_sys SHALL be ignored until mem_ack; the access SHALL retire per REQ-010.
REQ-018 mem_ack SHALL be ignored in IDLE.
REQ-019 The upstream stage holds its inputs while stall_out=1; the block SHALL sample in_* on the retire edge.

Reset
REQ-020 Asserting rst SHALL immediately force: FSM=IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; out_wb_data=0; out_r0_en=0; out_instr=0; out_valid=0; out_mem_err=0; timeout counter=0.
REQ-021 rst asserted during WAIT SHALL abandon the access with no retire. A mem_ack arriving after reset release SHALL be ignored per REQ-018.

Configuration
REQ-022 With macro STAGE_THREE_TIMEOUT_EN defined, a 4-bit counter SHALL clear on WAIT entry and increment each non-ack WAIT cycle.
REQ-023 Under STAGE_THREE_TIMEOUT_EN, when the counter reaches 15 without mem_ack, the block SHALL at the next edge: drop mem_req; return to IDLE; set out_valid=0 and out_r0_en=0; pulse out_mem_err for exactly 1 cycle. stall_out SHALL deassert in that cycle.
REQ-024 Without STAGE_THREE_TIMEOUT_EN, no counter SHALL exist, out_mem_err SHALL be constant 0, and WAIT SHALL last until mem_ack.

Verification
REQ-025 Reset then ALU op: in_memc=00, in_alu=32'h0001_2345, in_r0_en=1 -> one edge later out_wb_data=32'h0001_2345, out_valid=1, stall_out never 1.
REQ-026 Load with ack after 3 WAIT cycles: in_alu=16'h0040, mem_rdata=16'hBEEF -> mem_addr=16'h0040 and mem_we=0 held 4 cycles; stall_out=1 for 4 cycles; out_wb_data=32'h0000_BEEF and out_valid=1 on the retire edge.
REQ-027 Store: in_alu=16'h0010, in_r1_data=16'hA5A5, ack in first WAIT cycle -> mem_we=1 and mem_wdata=16'hA5A5; out_r0_en=0; total latency 2 cycles.
REQ-028 halt_sys=1 asserted in WAIT with ack 2 cycles later -> access retires normally; next load is not launched until halt_sys=0.
REQ-029 rst pulsed mid-WAIT -> mem_req=0 immediately, out_valid=0; a later stray mem_ack produces no output change.
REQ-030 With STAGE_THREE_TIMEOUT_EN, load with no ack -> mem_req drops after 16 WAIT cycles, out_mem_err=1 for 1 cycle, stall_out=0 thereafter. Without the macro -> request held indefinitely and out_mem_err stays 0.

Source files
------------

// File: rtl/stage_three.sv
// rtl/stage_three.sv - pipeline stage three: data-memory load/store handshake and retire register
// Optional feature: define STAGE_THREE_TIMEOUT_EN to abort accesses left unacknowledged for 16 WAIT cycles.
module stage_three (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic [1:0]  in_memc,
  input  logic [31:0] in_alu,
  input  logic [15:0] in_r1_data,
  input  logic        in_r0_en,
  input  logic [15:0] in_instr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_out,
  output logic [31:0] out_wb_data,
  output logic        out_r0_en,
  output logic [15:0] out_instr,
  output logic        out_valid,
  output logic        out_mem_err
);

  localparam logic [1:0] MEMC_LOAD  = 2'b01;
  localparam logic [1:0] MEMC_STORE = 2'b10;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mem_req, w_mem_req_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [15:0] r_mem_addr, w_mem_addr_nxt;
  logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [31:0] r_wb_data, w_wb_data_nxt;
  logic        r_r0_en, w_r0_en_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic        r_valid, w_valid_nxt;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_timeout;

  // 2'b11 is deliberately decoded as a non-memory instruction.
  assign w_is_load  = (in_memc == MEMC_LOAD);
  assign w_is_store = (in_memc == MEMC_STORE);
  assign w_is_mem   = w_is_load || w_is_store;

`ifdef STAGE_THREE_TIMEOUT_EN
  logic [3:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic       r_mem_err, w_mem_err_nxt;

  assign w_timeout   = (r_state == WAIT) && !mem_ack && (r_tmo_cnt == 4'd15);
  assign out_mem_err = r_mem_err;
`else
  assign w_timeout   = 1'b0;
  assign out_mem_err = 1'b0;
`endif

  // Upstream is released in the timeout cycle so the failed instruction is dropped.
  assign stall_out = ((r_state == IDLE) && w_is_mem && !halt_sys) ||
                     ((r_state == WAIT) && !mem_ack && !w_timeout);

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wb_data_nxt   = r_wb_data;
    w_r0_en_nxt     = r_r0_en;
    w_instr_nxt     = r_instr;
    w_valid_nxt     = r_valid;
`ifdef STAGE_THREE_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_mem_err_nxt   = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (!halt_sys) begin
          if (w_is_mem) begin
            w_state_nxt     = WAIT;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = w_is_store;
            w_mem_addr_nxt  = in_alu[15:0];
            w_mem_wdata_nxt = in_r1_data;
            w_valid_nxt     = 1'b0;
            w_r0_en_nxt     = 1'b0;
`ifdef STAGE_THREE_TIMEOUT_EN
            w_tmo_cnt_nxt   = 4'd0;
`endif
          end else begin
            w_wb_data_nxt = in_alu;
            w_r0_en_nxt   = in_r0_en;
            w_instr_nxt   = in_instr;
            w_valid_nxt   = 1'b1;
          end
        end
      end

      WAIT: begin
        if (mem_ack) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_instr_nxt   = in_instr;
          w_valid_nxt   = 1'b1;
          // The launched direction is taken from the held request, not in_memc.
          if (r_mem_we) begin
            w_wb_data_nxt = in_alu;
            w_r0_en_nxt   = 1'b0;
          end else begin
            w_wb_data_nxt = {16'd0, mem_rdata};
            w_r0_en_nxt   = in_r0_en;
          end
        end else if (w_timeout) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_valid_nxt   = 1'b0;
          w_r0_en_nxt   = 1'b0;
`ifdef STAGE_THREE_TIMEOUT_EN
          w_mem_err_nxt = 1'b1;
`endif
        end else begin
          w_valid_nxt   = 1'b0;
          w_r0_en_nxt   = 1'b0;
`ifdef STAGE_THREE_TIMEOUT_EN
          w_tmo_cnt_nxt = r_tmo_cnt + 4'd1;
`endif
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'd0;
      r_mem_wdata <= 16'd0;
      r_wb_data   <= 32'd0;
      r_r0_en     <= 1'b0;
      r_instr     <= 16'd0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_r0_en     <= w_r0_en_nxt;
      r_instr     <= w_instr_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

`ifdef STAGE_THREE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= 4'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end
`endif

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign out_wb_data = r_wb_data;
  assign out_r0_en   = r_r0_en;
  assign out_instr   = r_instr;
  assign out_valid   = r_valid;

endmodule

// File: tb/tb_stage_three.sv
// tb/tb_stage_three.sv - scoreboard bench for stage_three with directed load/store/ALU vectors
module tb_stage_three;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic [1:0]  in_memc;
  logic [31:0] in_alu;
  logic [15:0] in_r1_data;
  logic        in_r0_en;
  logic [15:0] in_instr;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_out;
  logic [31:0] out_wb_data;
  logic        out_r0_en;
  logic [15:0] out_instr;
  logic        out_valid;
  logic        out_mem_err;

  typedef struct packed {
    logic [31:0] wb;
    logic        r0;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  stage_three dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_memc(in_memc), .in_alu(in_alu),
    .in_r1_data(in_r1_data), .in_r0_en(in_r0_en), .in_instr(in_instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
    .out_wb_data(out_wb_data), .out_r0_en(out_r0_en), .out_instr(out_instr),
    .out_valid(out_valid), .out_mem_err(out_mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops one expected result per newly retired instruction (each vector uses a unique instr tag).
  task automatic monitor_loop();
    logic        pv = 1'b0;
    logic [15:0] pi = 16'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (out_valid && (!pv || out_instr != pi)) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_retire", 32'(out_instr), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("sb_wb_data", out_wb_data, e.wb);
            chk("sb_r0_en", 32'(out_r0_en), 32'(e.r0));
            chk("sb_instr", 32'(out_instr), 32'(e.instr));
          end
        end
        pv = out_valid;
        pi = out_instr;
      end
    end
  endtask

  task automatic do_op(input logic [1:0] memc, input logic [31:0] alu, input logic [15:0] r1,
                       input logic r0, input logic [15:0] instr, input int ack_dly,
                       input logic [15:0] rdata, input logic halt_wait);
    int   stalls = 0;
    int   w = 0;
    logic is_mem;
    exp_t e;
    is_mem  = (memc == 2'b01) || (memc == 2'b10);
    e.instr = instr;
    if (memc == 2'b01) begin
      e.wb = {16'd0, rdata};
      e.r0 = r0;
    end else if (memc == 2'b10) begin
      e.wb = alu;
      e.r0 = 1'b0;
    end else begin
      e.wb = alu;
      e.r0 = r0;
    end
    sb.push_back(e);
    in_memc = memc; in_alu = alu; in_r1_data = r1; in_r0_en = r0; in_instr = instr;
    mem_rdata = rdata; mem_ack = 1'b0; halt_sys = 1'b0;
    #1;
    while (stall_out && stalls < 40) begin
      stalls++;
      @(posedge clk);
      @(negedge clk);
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_mem_addr", 32'(mem_addr), 32'(alu[15:0]));
      chk("wait_mem_we", 32'(mem_we), 32'(memc == 2'b10));
      chk("wait_mem_wdata", 32'(mem_wdata), 32'(r1));
      chk("wait_bubble", 32'({out_valid, out_r0_en}), 32'd0);
      chk("wait_mem_err", 32'(out_mem_err), 32'd0);
      if (halt_wait) halt_sys = 1'b1;
      mem_ack = (w == ack_dly);
      w++;
      #1;
    end
    chk("stall_cycles", 32'(stalls), is_mem ? 32'(ack_dly + 1) : 32'd0);
    @(posedge clk);
    @(negedge clk);
    halt_sys = 1'b1; mem_ack = 1'b0; in_memc = 2'b00;
    chk("req_after_retire", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; halt_sys = 1'b1; in_memc = 2'b00; in_alu = 32'd0; in_r1_data = 16'd0;
    in_r0_en = 1'b0; in_instr = 16'd0; mem_rdata = 16'd0; mem_ack = 1'b0;
    fork
      monitor_loop();
    join_none
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_wb_data", out_wb_data, 32'd0);
    chk("rst_r0_en", 32'(out_r0_en), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_err", 32'(out_mem_err), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(2'b00, 32'h0001_2345, 16'h0000, 1'b1, 16'h1001, 0, 16'h0000, 1'b0);
    do_op(2'b01, 32'h0000_0040, 16'h0000, 1'b1, 16'h2002, 3, 16'hBEEF, 1'b0);
    do_op(2'b10, 32'h0000_0010, 16'hA5A5, 1'b1, 16'h3003, 0, 16'h0000, 1'b0);
    do_op(2'b11, 32'hDEAD_BEEF, 16'h1234, 1'b0, 16'h4004, 0, 16'h0000, 1'b0);
    do_op(2'b01, 32'hABCD_1234, 16'h0000, 1'b0, 16'h5005, 1, 16'h7F00, 1'b0);
    do_op(2'b01, 32'h0000_0080, 16'h0000, 1'b1, 16'h6006, 2, 16'h1111, 1'b1);

    // halt in IDLE: load presented but must neither launch nor disturb outputs
    in_memc = 2'b01; in_alu = 32'h0000_0090; in_instr = 16'h7007; in_r0_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_stall", 32'(stall_out), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("halt_no_launch", 32'(mem_req), 32'd0);
      chk("halt_freeze_instr", 32'(out_instr), 32'h6006);
      chk("halt_freeze_wb", out_wb_data, 32'h0000_1111);
    end
    do_op(2'b01, 32'h0000_0090, 16'h0000, 1'b1, 16'h7007, 0, 16'h2222, 1'b0);
    do_op(2'b00, 32'h0000_7777, 16'h0000, 1'b0, 16'h7107, 0, 16'h0000, 1'b0);

`ifdef STAGE_THREE_TIMEOUT_EN
    in_memc = 2'b01; in_alu = 32'h0000_00C0; in_instr = 16'hA00A; halt_sys = 1'b0;
    #1;
    chk("tmo_launch_stall", 32'(stall_out), 32'd1);
    @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      chk("tmo_req_held", 32'(mem_req), 32'd1);
      chk("tmo_stall", 32'(stall_out), 32'(w < 15));
      if (w < 15) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    @(posedge clk);
    @(negedge clk);
    halt_sys = 1'b1; in_memc = 2'b00;
    chk("tmo_req_drop", 32'(mem_req), 32'd0);
    chk("tmo_err_pulse", 32'(out_mem_err), 32'd1);
    chk("tmo_valid", 32'({out_valid, out_r0_en}), 32'd0);
    #1;
    chk("tmo_stall_after", 32'(stall_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_err_cleared", 32'(out_mem_err), 32'd0);
`else
    do_op(2'b01, 32'h0000_00C0, 16'h0000, 1'b1, 16'hA00A, 20, 16'h3333, 1'b0);
`endif

    // reset in the middle of an access abandons it without retiring
    in_memc = 2'b01; in_alu = 32'h0000_00A0; in_instr = 16'h8008; halt_sys = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_wb", out_wb_data, 32'd0);
    halt_sys = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stray_ack_req", 32'(mem_req), 32'd0);
      chk("stray_ack_valid", 32'(out_valid), 32'd0);
      chk("stray_ack_instr", 32'(out_instr), 32'd0);
    end
    mem_ack = 1'b0;
    do_op(2'b00, 32'h0000_9999, 16'h0000, 1'b1, 16'h9009, 0, 16'h0000, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
